// File: rtl/scaler_pkg.sv
// Shared types and sizing helpers for the scaler input stage.
package scaler_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int DEF_CH        = 3;
  localparam int DEF_CH_W      = 8;
  localparam int DEF_DATA_W    = DEF_CH * DEF_CH_W;
  localparam int DEF_K_W       = 8;
  localparam int DEF_LINE_BUFS = 4;

  // Slot index width; a single-slot ring still needs a 1-bit pointer.
  function automatic int slot_bits(input int bufs);
    return (bufs > 1) ? $clog2(bufs) : 1;
  endfunction

  // Accumulator start value; the first step always carries out of it.
  function automatic logic [63:0] acc_init(input int k_w);
    return (64'd1 << k_w) - 64'd1;
  endfunction

endpackage

// File: rtl/scaler_input_ctrl_p_phase_acc.sv
// Phase accumulator deciding which pixels or rows survive decimation.
module scaler_phase_acc
  import scaler_pkg::*;
#(
  parameter int K_W = DEF_K_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K_W-1:0] step,
  input  logic           evt,
  input  logic           init,
  input  logic           reload,
  output logic           keep
);

  localparam logic [K_W-1:0] ALL_ONES = K_W'(acc_init(K_W));

  logic [K_W-1:0] acc;
  logic [K_W-1:0] cur;
  logic [K_W:0]   sum;

  // init makes this cycle behave as if the accumulator had just been reloaded.
  assign cur  = init ? ALL_ONES : acc;
  assign sum  = {1'b0, cur} + {1'b0, step} + (K_W+1)'(1);
  assign keep = sum[K_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc <= ALL_ONES;
    else if (reload) acc <= ALL_ONES;
    else if (evt)    acc <= sum[K_W-1:0];
    else if (init)   acc <= ALL_ONES;
  end

endmodule

// File: rtl/scaler_input_ctrl_p.sv
// Scaler input stage: window crop, X/Y phase decimation, line-buffer ring
// writes and slot credit tracking toward the downstream interpolator.
module scaler_input_ctrl_p
  import scaler_pkg::*;
#(
  parameter  int CH        = DEF_CH,
  parameter  int CH_W      = DEF_CH_W,
  parameter  int X_W       = 10,
  parameter  int Y_W       = 10,
  parameter  int K_W       = DEF_K_W,
  parameter  int LINE_BUFS = DEF_LINE_BUFS,
  localparam int DATA_W    = CH * CH_W,
  localparam int SLOT_W    = slot_bits(LINE_BUFS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [X_W-1:0]        x_bgn,
  input  logic [X_W-1:0]        x_end,
  input  logic [Y_W-1:0]        y_bgn,
  input  logic [Y_W-1:0]        y_end,
  input  logic [K_W-1:0]        k_x,
  input  logic [K_W-1:0]        k_y,
  input  logic                  din_en,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_sof,
  input  logic                  din_eol,
  input  logic                  line_release,
  output logic                  ram_wr_en,
  output logic [SLOT_W+X_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic                  line_done,
  output logic [SLOT_W-1:0]     line_slot,
  output logic [X_W-1:0]        line_len,
  output logic [SLOT_W:0]       lines_used,
  output logic                  h_valid,
  output logic                  v_valid,
  output logic                  frame_done,
  output logic                  ovf
);

  state_t state;

  logic           cfg_en;
  logic [X_W-1:0] cfg_xb, cfg_xe;
  logic [Y_W-1:0] cfg_yb, cfg_ye;
  logic [K_W-1:0] cfg_kx, cfg_ky;

  logic [X_W-1:0]    x_r, wr_cnt, len_p1;
  logic [Y_W-1:0]    y_r;
  logic              row_decided, row_commit, done_p1;
  logic [SLOT_W-1:0] slot_ptr, slot_p1;

  logic              accept, sof_acc, eol_acc;
  logic              e_en;
  logic [X_W-1:0]    e_xb, e_xe, cur_x, cur_cnt;
  logic [Y_W-1:0]    e_yb, e_ye, cur_y;
  logic [K_W-1:0]    e_kx, e_ky;
  logic              cur_decided, cur_commit;
  logic              h_in, v_in, x_evt, y_evt, keep_x, keep_y;
  logic              pix_kept, first, commit_now, row_on, write, dec;
  logic [SLOT_W+1:0] occ;

  // The sof pixel runs on the freshly presented settings and a clean row.
  assign accept  = din_en && (state == ACTIVE || din_sof);
  assign sof_acc = din_en && din_sof;
  assign eol_acc = accept && din_eol;

  assign e_en = sof_acc ? en    : cfg_en;
  assign e_xb = sof_acc ? x_bgn : cfg_xb;
  assign e_xe = sof_acc ? x_end : cfg_xe;
  assign e_yb = sof_acc ? y_bgn : cfg_yb;
  assign e_ye = sof_acc ? y_end : cfg_ye;
  assign e_kx = sof_acc ? k_x   : cfg_kx;
  assign e_ky = sof_acc ? k_y   : cfg_ky;

  assign cur_x       = sof_acc ? '0   : x_r;
  assign cur_y       = sof_acc ? '0   : y_r;
  assign cur_cnt     = sof_acc ? '0   : wr_cnt;
  assign cur_decided = sof_acc ? 1'b0 : row_decided;
  assign cur_commit  = sof_acc ? 1'b0 : row_commit;

  assign h_in  = (cur_x >= e_xb) && (cur_x <= e_xe);
  assign v_in  = (cur_y >= e_yb) && (cur_y <= e_ye);
  assign x_evt = accept && h_in && v_in;
  assign y_evt = eol_acc && v_in;

  scaler_phase_acc #(.K_W(K_W)) u_acc_x (
    .clk(clk), .rst(rst), .step(e_kx), .evt(x_evt),
    .init(sof_acc), .reload(eol_acc), .keep(keep_x)
  );

  scaler_phase_acc #(.K_W(K_W)) u_acc_y (
    .clk(clk), .rst(rst), .step(e_ky), .evt(y_evt),
    .init(sof_acc), .reload(1'b0), .keep(keep_y)
  );

  // Completed lines still in the done pipeline already own a slot.
  assign occ = (SLOT_W+2)'(lines_used) + (SLOT_W+2)'(done_p1) + (SLOT_W+2)'(line_done);

  assign pix_kept   = x_evt && (keep_x || !e_en) && (keep_y || !e_en);
  assign first      = pix_kept && !cur_decided;
  assign commit_now = first && (occ < (SLOT_W+2)'(LINE_BUFS));
  assign row_on     = cur_commit || commit_now;
  assign write      = pix_kept && row_on;
  assign dec        = line_release && ((lines_used != '0) || line_done);

  assign h_valid = (state == ACTIVE) && (x_r >= cfg_xb) && (x_r <= cfg_xe);
  assign v_valid = (state == ACTIVE) && (y_r >= cfg_yb) && (y_r <= cfg_ye);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cfg_en      <= 1'b0;
      cfg_xb      <= '0;
      cfg_xe      <= '0;
      cfg_yb      <= '0;
      cfg_ye      <= '0;
      cfg_kx      <= '0;
      cfg_ky      <= '0;
      x_r         <= '0;
      y_r         <= '0;
      wr_cnt      <= '0;
      row_decided <= 1'b0;
      row_commit  <= 1'b0;
      slot_ptr    <= '0;
      done_p1     <= 1'b0;
      slot_p1     <= '0;
      len_p1      <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      line_done   <= 1'b0;
      line_slot   <= '0;
      line_len    <= '0;
      lines_used  <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      ram_wr_en  <= write;
      frame_done <= 1'b0;
      done_p1    <= 1'b0;
      line_done  <= done_p1;
      ovf        <= (ovf && !sof_acc) || (first && !commit_now);

      if (done_p1) begin
        line_slot <= slot_p1;
        line_len  <= len_p1;
      end

      unique case ({line_done, dec})
        2'b10:   lines_used <= lines_used + 1'b1;
        2'b01:   lines_used <= lines_used - 1'b1;
        default: lines_used <= lines_used;
      endcase

      if (write) begin
        ram_wr_addr <= {slot_ptr, cur_cnt};
        ram_wr_data <= din;
      end

      if (sof_acc) begin
        cfg_en <= en;
        cfg_xb <= x_bgn;
        cfg_xe <= x_end;
        cfg_yb <= y_bgn;
        cfg_ye <= y_end;
        cfg_kx <= k_x;
        cfg_ky <= k_y;
      end

      if (accept) begin
        if (eol_acc) begin
          x_r         <= '0;
          y_r         <= cur_y + 1'b1;
          wr_cnt      <= '0;
          row_decided <= 1'b0;
          row_commit  <= 1'b0;
          if (row_on) begin
            done_p1  <= 1'b1;
            slot_p1  <= slot_ptr;
            len_p1   <= cur_cnt + X_W'(write);
            slot_ptr <= slot_ptr + 1'b1;
          end
        end else begin
          x_r         <= cur_x + 1'b1;
          y_r         <= cur_y;
          wr_cnt      <= cur_cnt + X_W'(write);
          row_decided <= cur_decided || first;
          row_commit  <= row_on;
        end

        if (eol_acc && (cur_y == e_ye)) begin
          state      <= IDLE;
          frame_done <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_scaler_input_ctrl_p.sv
// Randomised and directed bench for scaler_input_ctrl_p against a frame-level
// reference model built from window, phase-ratio and slot-credit rules.
module tb_scaler_input_ctrl_p;

  localparam int X_W = 10, Y_W = 10, K_W = 8, LB = 4;
  localparam int DATA_W = 24, SLOT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [X_W-1:0] x_bgn = '0, x_end = '0;
  logic [Y_W-1:0] y_bgn = '0, y_end = '0;
  logic [K_W-1:0] k_x = '0, k_y = '0;
  logic din_en = 1'b0, din_sof = 1'b0, din_eol = 1'b0, line_release = 1'b0;
  logic [DATA_W-1:0] din = '0;

  logic                  ram_wr_en;
  logic [SLOT_W+X_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0]     ram_wr_data;
  logic                  line_done;
  logic [SLOT_W-1:0]     line_slot;
  logic [X_W-1:0]        line_len;
  logic [SLOT_W:0]       lines_used;
  logic                  h_valid, v_valid, frame_done, ovf;

  scaler_input_ctrl_p #(
    .CH(3), .CH_W(8), .X_W(X_W), .Y_W(Y_W), .K_W(K_W), .LINE_BUFS(LB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .x_bgn(x_bgn), .x_end(x_end), .y_bgn(y_bgn), .y_end(y_end),
    .k_x(k_x), .k_y(k_y),
    .din_en(din_en), .din(din), .din_sof(din_sof), .din_eol(din_eol),
    .line_release(line_release),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .line_done(line_done), .line_slot(line_slot), .line_len(line_len),
    .lines_used(lines_used), .h_valid(h_valid), .v_valid(v_valid),
    .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state: frame settings, position, window/phase indices, slot credit.
  bit m_active, m_en, m_ovf;
  int m_xb, m_xe, m_yb, m_ye, m_kx, m_ky;
  int m_x, m_y, m_hi, m_vi, m_row, m_wcnt, m_slot, m_used;
  bit p_en;
  int p_slot, p_len;
  int obs_done, obs_last_len, obs_last_slot, obs_wr;
  longint obs_first_data;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Event i of a run is kept when (k+1)/2^K_W of progress crosses an integer.
  function automatic bit phase_keep(input int i, input int k);
    int m;
    m = 1 << K_W;
    return ((m - 1 + (i + 1) * (k + 1)) / m) != ((m - 1 + i * (k + 1)) / m);
  endfunction

  task automatic applyStimulus(input bit den, input bit sof, input bit eol,
                               input logic [DATA_W-1:0] d, input bit rel);
    bit e_wr = 0, n_pend = 0, e_fd = 0, hin = 0, vin = 0, pk = 0;
    int e_addr = 0, n_slot = 0, n_len = 0;
    logic [DATA_W-1:0] e_data = '0;
    if (den && (m_active || sof)) begin
      if (sof) begin
        m_active = 1; m_en = en;
        m_xb = int'(x_bgn); m_xe = int'(x_end); m_yb = int'(y_bgn); m_ye = int'(y_end);
        m_kx = int'(k_x); m_ky = int'(k_y);
        m_x = 0; m_y = 0; m_hi = 0; m_vi = 0; m_row = 0; m_wcnt = 0; m_ovf = 0;
      end
      hin = (m_x >= m_xb) && (m_x <= m_xe);
      vin = (m_y >= m_yb) && (m_y <= m_ye);
      if (hin && vin) begin
        pk = (!m_en || phase_keep(m_hi, m_kx)) && (!m_en || phase_keep(m_vi, m_ky));
        m_hi++;
      end
      if (pk) begin
        if (m_row == 0) begin
          if (m_used < LB) m_row = 1;
          else begin m_row = 2; m_ovf = 1; end
        end
        if (m_row == 1) begin
          e_wr = 1; e_addr = m_slot * (1 << X_W) + m_wcnt; e_data = d; m_wcnt++;
        end
      end
      if (eol) begin
        if (m_row == 1) begin
          n_pend = 1; n_slot = m_slot; n_len = m_wcnt;
          m_used++; m_slot = (m_slot + 1) % LB;
        end
        if (vin) m_vi++;
        if (m_y == m_ye) begin e_fd = 1; m_active = 0; end
        m_x = 0; m_y++; m_hi = 0; m_row = 0; m_wcnt = 0;
      end else begin
        m_x++;
      end
    end
    if (rel && m_used > 0) m_used--;

    din_en = den; din_sof = sof; din_eol = eol; din = d; line_release = rel;
    @(posedge clk);
    #1;
    checkOutput("wr_en", ram_wr_en, e_wr);
    if (e_wr) begin
      checkOutput("wr_addr", ram_wr_addr, e_addr);
      checkOutput("wr_data", ram_wr_data, e_data);
    end
    if (ram_wr_en) begin
      if (obs_wr == 0) obs_first_data = ram_wr_data;
      obs_wr++;
    end
    checkOutput("line_done", line_done, p_en);
    if (p_en) begin
      checkOutput("line_slot", line_slot, p_slot);
      checkOutput("line_len", line_len, p_len);
    end
    if (line_done) begin
      obs_done++; obs_last_len = line_len; obs_last_slot = line_slot;
    end
    checkOutput("frame_done", frame_done, e_fd);
    checkOutput("h_valid", h_valid, m_active && m_x >= m_xb && m_x <= m_xe);
    checkOutput("v_valid", v_valid, m_active && m_y >= m_yb && m_y <= m_ye);
    p_en = n_pend; p_slot = n_slot; p_len = n_len;
  endtask

  task automatic idle(input bit rel);
    applyStimulus(0, 0, 0, '0, rel);
  endtask

  task automatic resetDut(input bit chk);
    din_en = 0; din_sof = 0; din_eol = 0; line_release = 0;
    #2 rst = 0;
    #1;
    if (chk) begin
      checkOutput("rst_wr_en", ram_wr_en, 0);
      checkOutput("rst_wr_addr", ram_wr_addr, 0);
      checkOutput("rst_wr_data", ram_wr_data, 0);
      checkOutput("rst_line_done", line_done, 0);
      checkOutput("rst_line_len", line_len, 0);
      checkOutput("rst_lines_used", lines_used, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_ovf", ovf, 0);
      checkOutput("rst_h_valid", h_valid, 0);
      checkOutput("rst_v_valid", v_valid, 0);
    end
    m_active = 0; m_used = 0; m_slot = 0; m_ovf = 0; p_en = 0;
    obs_done = 0; obs_wr = 0; obs_first_data = 0; obs_last_len = 0; obs_last_slot = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic setCfg(input bit e, input int xb, input int xe, input int yb,
                        input int ye, input int kx, input int ky);
    en = e; x_bgn = X_W'(xb); x_end = X_W'(xe); y_bgn = Y_W'(yb); y_end = Y_W'(ye);
    k_x = K_W'(kx); k_y = K_W'(ky);
  endtask

  function automatic logic [DATA_W-1:0] pix(input int r, input int c, input bit rnd);
    return rnd ? DATA_W'($urandom) : DATA_W'(r * 16 + c);
  endfunction

  task automatic quietCheck();
    checkOutput("lines_used", lines_used, m_used);
    checkOutput("ovf", ovf, m_ovf);
  endtask

  task automatic driveRow(input int r, input int w, input bit rnd);
    for (int c = 0; c < w; c++) begin
      if (rnd && $urandom_range(3) == 0) idle(0);
      applyStimulus(1, r == 0 && c == 0, c == w - 1, pix(r, c, rnd), 0);
      if (rnd && r == 0 && c == 0)
        setCfg($urandom_range(1), $urandom_range(9), $urandom_range(9),
               $urandom_range(7), $urandom_range(7), $urandom_range(255), $urandom_range(255));
    end
    repeat (3) idle(0);
    if (rnd) repeat ($urandom_range(2)) idle($urandom_range(1));
  endtask

  task automatic runFrame(input int w, input int h, input bit rnd, input int stop_row);
    for (int r = 0; r < h; r++) begin
      if (r == stop_row) begin
        for (int c = 0; c < 3; c++) applyStimulus(1, r == 0 && c == 0, 0, pix(r, c, rnd), 0);
        return;
      end
      driveRow(r, w, rnd);
    end
  endtask

  initial begin
    resetDut(1);

    // Crop only: rows 1..2, columns 2..5.
    setCfg(0, 2, 5, 1, 2, 0, 0);
    runFrame(8, 4, 0, -1);
    quietCheck();
    checkOutput("t1_lines", obs_done, 2);
    checkOutput("t1_last_slot", obs_last_slot, 1);
    checkOutput("t1_len", obs_last_len, 4);
    checkOutput("t1_first_data", obs_first_data, 'h12);

    // Half-rate decimation in both directions.
    resetDut(0);
    setCfg(1, 0, 7, 0, 3, 127, 127);
    runFrame(8, 4, 0, -1);
    quietCheck();
    checkOutput("t2_lines", obs_done, 2);
    checkOutput("t2_len", obs_last_len, 4);

    // One-in-three columns, every row.
    resetDut(0);
    setCfg(1, 0, 7, 0, 3, 84, 255);
    runFrame(8, 4, 0, -1);
    quietCheck();
    checkOutput("t3_lines", obs_done, 4);
    checkOutput("t3_len", obs_last_len, 3);

    // Ring exhaustion with no releases.
    resetDut(0);
    setCfg(0, 0, 7, 0, 5, 0, 0);
    runFrame(8, 6, 0, -1);
    quietCheck();
    checkOutput("t4_lines", obs_done, 4);
    checkOutput("t4_used_full", lines_used, 4);
    checkOutput("t4_ovf", ovf, 1);
    idle(1);
    idle(0);
    checkOutput("t4_used_after_rel", lines_used, 3);

    // Release coincident with line_done, then release at empty.
    resetDut(0);
    setCfg(0, 0, 3, 0, 1, 0, 0);
    driveRow(0, 4, 0);
    for (int c = 0; c < 4; c++) applyStimulus(1, 0, c == 3, pix(1, c, 0), 0);
    idle(0);
    checkOutput("t5_done_high", line_done, 1);
    idle(1);
    idle(0);
    idle(0);
    checkOutput("t5_used_same", lines_used, 1);
    idle(1);
    idle(1);
    idle(0);
    checkOutput("t5_used_zero", lines_used, 0);
    quietCheck();

    // Restart mid-row 2, then a reset in the middle of a line.
    resetDut(0);
    setCfg(0, 0, 7, 0, 3, 0, 0);
    runFrame(8, 4, 0, 2);
    idle(1);
    idle(1);
    runFrame(8, 4, 0, -1);
    quietCheck();
    checkOutput("t6_lines", obs_done, 6);
    checkOutput("t6_last_slot", obs_last_slot, 1);
    repeat (4) idle(1);
    runFrame(8, 4, 0, 0);
    checkOutput("t6_wr_before_rst", ram_wr_en, 1);
    resetDut(1);
    for (int c = 3; c < 8; c++) applyStimulus(1, 0, c == 7, pix(0, c, 0), 0);
    idle(0);
    runFrame(8, 4, 0, -1);
    quietCheck();

    // Randomised frames: settings, sizes, gaps, data and releases.
    for (int f = 0; f < 24; f++) begin
      setCfg($urandom_range(1), $urandom_range(9), $urandom_range(9),
             $urandom_range(7), $urandom_range(7), $urandom_range(255), $urandom_range(255));
      runFrame($urandom_range(10, 2), $urandom_range(6, 1), 1, -1);
      repeat (3) idle(0);
      quietCheck();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
